// File: rtl/flipflop_bank.sv
// Bank of WIDTH run-time configurable SR/JK/D/T flip-flops with sticky
// forbidden-input flags and a saturating count of cycles in which Q changed.
module flipflop_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter int               SR_POLICY = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qn,
    output logic [WIDTH-1:0] o_err,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_forbid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return c;
        else
            return c + CNT_W'(1);
    endfunction

    function automatic logic sr_resolve(input logic s, input logic r, input logic q);
        logic res;
        case ({s, r})
            2'b10:   res = 1'b1;
            2'b01:   res = 1'b0;
            2'b11:   res = (SR_POLICY == 1) ? 1'b1 : (SR_POLICY == 2) ? 1'b0 : q;
            default: res = q;
        endcase
        return res;
    endfunction

    always_comb begin
        w_q_next = r_q;
        if (i_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case (i_mode)
                    MODE_SR: w_q_next[i] = sr_resolve(i_a[i], i_b[i], r_q[i]);
                    MODE_JK: begin
                        case ({i_a[i], i_b[i]})
                            2'b10:   w_q_next[i] = 1'b1;
                            2'b01:   w_q_next[i] = 1'b0;
                            2'b11:   w_q_next[i] = ~r_q[i];
                            default: w_q_next[i] = r_q[i];
                        endcase
                    end
                    MODE_D:  w_q_next[i] = i_a[i];
                    MODE_T:  w_q_next[i] = r_q[i] ^ i_a[i];
                    default: w_q_next[i] = r_q[i];
                endcase
            end
        end
    end

    // Forbidden-input detection is independent of SR_POLICY
    assign w_forbid = (i_en && i_mode == MODE_SR) ? (i_a & i_b) : '0;

    // Register stage: Q, Err and Cnt all update on the same edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q   <= INIT;
            r_err <= '0;
            r_cnt <= '0;
        end else begin
            r_q   <= w_q_next;
            r_err <= (i_clr_err ? '0 : r_err) | w_forbid;
            if (w_q_next != r_q)
                r_cnt <= sat_inc(r_cnt);
        end
    end

    assign o_q   = r_q;
    assign o_qn  = ~r_q;
    assign o_err = r_err;
    assign o_cnt = r_cnt;

endmodule

// File: tb/tb_flipflop_bank.sv
// Scoreboard bench for flipflop_bank: four instances (three SR policies plus a
// 3-bit counter variant) share stimulus; a monitor checks queued expectations.
module tb_flipflop_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       en;
    logic [7:0] a, b;
    logic       clr;

    logic [7:0] q0, qn0, err0, cnt0;
    logic [7:0] q1, qn1, err1, cnt1;
    logic [7:0] q2, qn2, err2, cnt2;
    logic [7:0] q3, qn3, err3;
    logic [2:0] cnt3;

    typedef struct {
        int         dut;
        logic [7:0] q;
        logic [7:0] err;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    flipflop_bank #(.WIDTH(8), .INIT(8'hA5), .SR_POLICY(0), .CNT_W(8)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_en(en), .i_a(a), .i_b(b),
        .i_clr_err(clr), .o_q(q0), .o_qn(qn0), .o_err(err0), .o_cnt(cnt0));
    flipflop_bank #(.WIDTH(8), .INIT(8'hA5), .SR_POLICY(1), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_en(en), .i_a(a), .i_b(b),
        .i_clr_err(clr), .o_q(q1), .o_qn(qn1), .o_err(err1), .o_cnt(cnt1));
    flipflop_bank #(.WIDTH(8), .INIT(8'hA5), .SR_POLICY(2), .CNT_W(8)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_en(en), .i_a(a), .i_b(b),
        .i_clr_err(clr), .o_q(q2), .o_qn(qn2), .o_err(err2), .o_cnt(cnt2));
    flipflop_bank #(.WIDTH(8), .INIT(8'hA5), .SR_POLICY(0), .CNT_W(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_en(en), .i_a(a), .i_b(b),
        .i_clr_err(clr), .o_q(q3), .o_qn(qn3), .o_err(err3), .o_cnt(cnt3));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge after each active edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] aq, aqn, aerr, acnt;
            e = sb.pop_front();
            case (e.dut)
                0:       begin aq = q0; aqn = qn0; aerr = err0; acnt = cnt0; end
                1:       begin aq = q1; aqn = qn1; aerr = err1; acnt = cnt1; end
                2:       begin aq = q2; aqn = qn2; aerr = err2; acnt = cnt2; end
                default: begin aq = q3; aqn = qn3; aerr = err3; acnt = {5'b0, cnt3}; end
            endcase
            check({e.tag, ".q"},   aq,   e.q);
            check({e.tag, ".qn"},  aqn,  ~e.q);
            check({e.tag, ".err"}, aerr, e.err);
            check({e.tag, ".cnt"}, acnt, e.cnt);
        end
    end

    task automatic drive(input logic r, input logic [1:0] m, input logic e,
                         input logic [7:0] va, input logic [7:0] vb, input logic c);
        @(negedge clk);
        #1;
        rst = r; mode = m; en = e; a = va; b = vb; clr = c;
    endtask

    task automatic expect_out(input int d, input logic [7:0] vq, input logic [7:0] verr,
                              input logic [7:0] vcnt, input string tag);
        exp_t e;
        e.dut = d; e.q = vq; e.err = verr; e.cnt = vcnt;
        e.tag = $sformatf("%s/d%0d", tag, d);
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; en = 1'b0; a = 8'h00; b = 8'h00; clr = 1'b0;

        drive(1, 2'b00, 0, 8'h00, 8'h00, 0); expect_out(0, 8'hA5, 8'h00, 8'd0, "rst");
        expect_out(3, 8'hA5, 8'h00, 8'd0, "rst");
        drive(1, 2'b00, 1, 8'hFF, 8'h00, 0); expect_out(0, 8'hA5, 8'h00, 8'd0, "rst_hold");

        drive(0, 2'b00, 1, 8'h00, 8'hFF, 0); expect_out(0, 8'h00, 8'h00, 8'd1, "sr_clr");
        drive(0, 2'b00, 1, 8'hFF, 8'h00, 0); expect_out(0, 8'hFF, 8'h00, 8'd2, "sr_set");
        drive(0, 2'b00, 1, 8'h0F, 8'hF0, 0); expect_out(0, 8'h0F, 8'h00, 8'd3, "sr_mix");
        drive(0, 2'b00, 1, 8'hFF, 8'hFF, 0);
        expect_out(0, 8'h0F, 8'hFF, 8'd3, "sr_forbid");
        expect_out(1, 8'hFF, 8'hFF, 8'd4, "sr_forbid");
        expect_out(2, 8'h00, 8'hFF, 8'd4, "sr_forbid");
        drive(0, 2'b00, 1, 8'h01, 8'h01, 1);
        expect_out(0, 8'h0F, 8'h01, 8'd3, "clr_vs_set");
        expect_out(1, 8'hFF, 8'h01, 8'd4, "clr_vs_set");
        expect_out(2, 8'h00, 8'h01, 8'd4, "clr_vs_set");
        drive(0, 2'b00, 1, 8'h00, 8'hFF, 0); expect_out(0, 8'h00, 8'h01, 8'd4, "err_sticky");

        drive(0, 2'b01, 1, 8'hFF, 8'hFF, 0); expect_out(0, 8'hFF, 8'h01, 8'd5, "jk_tog1");
        drive(0, 2'b01, 1, 8'hFF, 8'hFF, 0); expect_out(0, 8'h00, 8'h01, 8'd6, "jk_tog2");
        drive(0, 2'b01, 1, 8'hFF, 8'hFF, 0); expect_out(0, 8'hFF, 8'h01, 8'd7, "jk_tog3");
        drive(0, 2'b11, 1, 8'h0F, 8'h00, 0); expect_out(0, 8'hF0, 8'h01, 8'd8, "t_tog");
        drive(0, 2'b01, 1, 8'h0F, 8'hF0, 0); expect_out(0, 8'h0F, 8'h01, 8'd9, "jk_setrst");
        drive(0, 2'b01, 1, 8'h00, 8'h00, 0); expect_out(0, 8'h0F, 8'h01, 8'd9, "jk_hold");

        drive(0, 2'b00, 0, 8'hFF, 8'hFF, 0); expect_out(0, 8'h0F, 8'h01, 8'd9, "en0_sr");
        drive(0, 2'b10, 0, 8'h3C, 8'h00, 1); expect_out(0, 8'h0F, 8'h00, 8'd9, "en0_clr");
        for (int k = 0; k < 3; k++) begin
            drive(0, 2'b10, 0, 8'h3C, 8'h00, 0); expect_out(0, 8'h0F, 8'h00, 8'd9, "en0_d");
        end
        drive(0, 2'b10, 1, 8'h3C, 8'h00, 0); expect_out(0, 8'h3C, 8'h00, 8'd10, "d_load");

        drive(1, 2'b11, 1, 8'h01, 8'h00, 0); expect_out(3, 8'hA5, 8'h00, 8'd0, "rst2");
        for (int k = 1; k <= 10; k++) begin
            drive(0, 2'b11, 1, 8'h01, 8'h00, 0);
            expect_out(3, (k % 2 == 1) ? 8'hA4 : 8'hA5, 8'h00, (k > 7) ? 8'd7 : 8'(k), "sat");
            expect_out(0, (k % 2 == 1) ? 8'hA4 : 8'hA5, 8'h00, 8'(k), "nosat");
        end
        drive(1, 2'b11, 1, 8'h01, 8'h00, 0); expect_out(3, 8'hA5, 8'h00, 8'd0, "rst_mid");
        drive(0, 2'b11, 1, 8'h01, 8'h00, 0); expect_out(3, 8'hA4, 8'h00, 8'd1, "resume");

        @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flipflop_bank.md
# flipflop_bank

Parametrised bank of WIDTH clocked, edge-triggered storage cells. Each cell is configured at run time as an SR, JK, D or T flip-flop. The bank replaces single-bit gated RS storage in the lab designs. It adds synchronous reset, a selectable resolution policy for the forbidden S=R=1 input, sticky per-channel forbidden-input flags, and a saturating count of cycles in which any output changed. It sits between the board switch/key inputs and the LEDR/HEX display logic of the latches and flip-flops exercises.

## Interface
- WIDTH, 8: number of independent storage channels (1..32).
- INIT, {WIDTH{1'b0}}: value loaded into Q on reset.
- SR_POLICY, 0: resolution of S=R=1 in SR mode. 0 = hold, 1 = set dominant, 2 = reset dominant.
- CNT_W, 8: width of the change counter.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clk.
- Mode  in  2  cell type, shared by all channels. 00 SR, 01 JK, 10 D, 11 T.
- En  in  1  clock enable. When 0, Q and Cnt hold; Err still holds or clears per ClrErr.
- A  in  WIDTH  per-channel first input: S, J, D or T depending on Mode.
- B  in  WIDTH  per-channel second input: R in SR, K in JK; ignored in D and T.
- ClrErr  in  1  synchronous clear of all Err bits.
- Q  out  WIDTH  registered state.
- Qn  out  WIDTH  always ~Q; never equal to Q.
- Err  out  WIDTH  sticky flag, set when channel i sees A=B=1 in SR mode with En=1.
- Cnt  out  CNT_W  saturating count of enabled cycles in which Q changed in at least one bit.

## Operation
- Reset has priority over all other inputs: Q=INIT, Qn=~INIT, Err=0, Cnt=0.
- With En=1, per channel i, next Q[i] is:
  - SR: A=1,B=0 → 1; A=0,B=1 → 0; A=0,B=0 → hold; A=1,B=1 → per SR_POLICY (hold, 1 or 0).
  - JK: 00 hold; 10 set; 01 reset; 11 toggle.
  - D: Q[i]=A[i]; B ignored.
  - T: A[i]=1 → toggle; A[i]=0 → hold.
- With En=0, Q holds regardless of A, B and Mode.
- Err[i] is set in the cycle after an enabled SR-mode edge with A[i]=B[i]=1, whatever SR_POLICY is.
  - ClrErr=1 clears all Err bits.
  - If ClrErr and a new forbidden input occur on the same edge, set wins: that bit reads 1 and the others read 0.
- Cnt increments by 1 on each enabled edge where next Q ≠ current Q.
  - Cnt saturates at 2^CNT_W−1 and does not wrap.
  - Cnt clears only on Reset.
- Mode may change on any cycle. The new mode applies from the edge at which it is sampled; there is no transition state.
- Qn is derived combinationally from registered Q, so it never glitches relative to Q.

## Timing
- Latency is one cycle. Inputs sampled at edge n appear on Q, Err and Cnt after edge n.
- No combinational path from any input to any output.
- A Reset asserted mid-sequence takes effect at the next edge; En is irrelevant in that cycle.
- Deasserting Reset lets normal operation resume on the following edge.
- All outputs are defined from the first edge with Reset=1. Before that first reset, output values are unspecified.

## Test plan
- Reset: WIDTH=8, INIT=8'hA5, assert Reset for 2 edges → Q=A5, Qn=5A, Err=00, Cnt=0. With Reset held, any A, B or En → values unchanged.
- SR policy: Mode=00, Q=00, then A=FF,B=00 → Q=FF. Next, A=0F,B=F0 → Q=0F. Next, A=B=FF:
  - SR_POLICY=0 → Q=0F.
  - SR_POLICY=1 → Q=FF.
  - SR_POLICY=2 → Q=00.
  - Err=FF in every case.
  - Then ClrErr=1 with A=B=01 → Err=01.
- JK/T toggle: Mode=01, Q=00, A=B=FF for 3 edges → Q=FF, 00, FF and Cnt=3. Switch Mode=11, A=0F for 1 edge → Q=F0, Cnt=4.
- Enable: Mode=10, En=0, A=3C for 5 edges → Q unchanged, Cnt unchanged. Set En=1 → Q=3C after 1 edge.
- Saturation: CNT_W=3, Mode=11, A=01, 10 enabled edges → Cnt reads 1..7 then stays 7. Q bit0 keeps toggling. Assert Reset mid-run → Cnt=0, Q=INIT on the next edge.
